tlul_adapter_host: RTL

TLUL_ADAPTER_HOST -- requirements
Module: tlul_adapter_host

---
 rtl/tlul_adapter_host.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/tlul_adapter_host.sv
// TL-UL host adapter: turns a simple req/gnt host port into single-beat
// TL-UL Get/PutFullData/PutPartialData requests with one transaction
// outstanding at a time, and returns a one-cycle response strobe.

package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

endpackage

module tlul_adapter_host
  import tlul_pkg::*;
#(
  parameter int SrcId         = 0,
  parameter int TimeoutCycles = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  typedef enum logic {
    IDLE,
    WAIT_D
  } state_e;

  // Base source id; bit 0 is always replaced by the alternating tag.
  localparam logic [TL_AIW-1:0] SrcBase = TL_AIW'(SrcId);

  // Counter only needs to reach TimeoutCycles-1.
  localparam int CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast =
    CntW'((TimeoutCycles > 0) ? (TimeoutCycles - 1) : 0);

  state_e            state;
  logic              tag;
  logic [TL_AIW-1:0] src_q;
  logic              is_read_q;
  logic [CntW-1:0]   cnt;

  logic              a_valid;
  logic [TL_AIW-1:0] a_source;
  logic              d_accept;
  logic              timeout_hit;
  tl_d_op_e          exp_d_op;

  // Fields the adapter never looks at; kept visible so the bus struct stays complete.
  logic unused_d_fields;
  assign unused_d_fields = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink};

  assign a_source = {SrcBase[TL_AIW-1:1], tag};

  // a_valid is gated by rst_ni so nothing is presented on the bus while in reset.
  assign a_valid  = rst_ni && (state == IDLE) && req_i;
  assign gnt_o    = a_valid && tl_i.a_ready;
  assign busy_o   = (state == WAIT_D);

  // Only the response carrying the outstanding transaction's source is ours.
  assign d_accept = (state == WAIT_D) && tl_i.d_valid && (tl_i.d_source == src_q);

  assign timeout_hit = (TimeoutCycles > 0) && (state == WAIT_D) && (cnt == CntLast);

  assign exp_d_op = is_read_q ? AccessAckData : AccessAck;

  // A-channel request built straight from the host inputs.
  always_comb begin
    // NOTE: every field gets a default first so no path leaves tl_o unassigned (no latch).
    tl_o           = '0;
    tl_o.a_valid   = a_valid;
    tl_o.a_param   = 3'd0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = a_source;
    tl_o.a_address = {addr_i[31:2], 2'b00};
    tl_o.d_ready   = 1'b1;
    if (we_i) begin
      tl_o.a_opcode = (be_i == 4'hF) ? PutFullData : PutPartialData;
      tl_o.a_mask   = be_i;
      tl_o.a_data   = wdata_i;
    end else begin
      tl_o.a_opcode = Get;
      tl_o.a_mask   = 4'hF;
      tl_o.a_data   = '0;
    end
  end

  // Transaction FSM with registered response outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: every register here has a reset value, so an abandoned transaction leaves no trace.
    if (!rst_ni) begin
      state     <= IDLE;
      tag       <= 1'b0;
      src_q     <= '0;
      is_read_q <= 1'b0;
      cnt       <= '0;
      valid_o   <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so each register sees pre-edge values.
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_o) begin
            state     <= WAIT_D;
            src_q     <= a_source;
            is_read_q <= !we_i;
            tag       <= ~tag;
            cnt       <= '0;
          end
        end
        WAIT_D: begin
          // A matching D beat takes priority over a timeout in the same cycle.
          if (d_accept) begin
            state   <= IDLE;
            valid_o <= 1'b1;
            rdata_o <= is_read_q ? tl_i.d_data : '0;
            err_o   <= tl_i.d_error || (tl_i.d_opcode != exp_d_op);
          end else if (timeout_hit) begin
            state   <= IDLE;
            valid_o <= 1'b1;
            rdata_o <= '0;
            err_o   <= 1'b1;
          end else if (TimeoutCycles > 0) begin
            cnt <= cnt + CntW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
